// File: rtl/draw_scheduler.sv
// draw_scheduler: sequences LUT-driven display init, a full 12x16 grid sweep and queued single-cell redraws.
module draw_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [3:0] upd_x,
  input  logic [3:0] upd_y,
  input  logic [2:0] obj_in,
  input  logic       cmd_finished,
  input  logic       pause,
  input  logic       tx_done,
  output logic [2:0] mode,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic [2:0] obj_code,
  output logic       tx_start,
  output logic       lut_clr,
  output logic       busy,
  output logic       init_done,
  output logic       err_oob
);
  typedef enum logic [2:0] {IDLE, I_SET, I_SEND, PICK, C_SET, C_SEND, CLR} state_t;
  state_t     state_q, state_d;
  logic       sweep_q, sweep_d, init_q, init_d, oob_q, oob_d;
  logic       pick_q, pick_d, cell_sw_q, cell_sw_d, tx_q, tx_d;
  logic [3:0] sx_q, sx_d, sy_q, sy_d, x_q, x_d, y_q, y_d;
  logic [2:0] obj_q, obj_d;
  logic [7:0] fifo_q [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       push, store, pop, fifo_ne;
  // Out-of-range requests complete the handshake but never enter the queue.
  always_comb begin
    upd_ready = cnt_q != 3'd4;
    fifo_ne   = cnt_q != 3'd0;
    push      = upd_valid && upd_ready;
    store     = push && upd_x <= 4'd11;
    pop       = state_q == PICK && !pick_q && !sweep_q;
    oob_d     = oob_q | (push && upd_x > 4'd11);
    wr_d      = store ? wr_q + 2'd1 : wr_q;
    rd_d      = pop ? rd_q + 2'd1 : rd_q;
    cnt_d     = cnt_q + {2'b0, store} - {2'b0, pop};
  end
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    init_d    = init_q;
    pick_d    = pick_q;
    cell_sw_d = cell_sw_q;
    tx_d      = 1'b0;
    sx_d      = sx_q;
    sy_d      = sy_q;
    x_d       = x_q;
    y_d       = y_q;
    obj_d     = obj_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sweep_d = 1'b1;
          state_d = init_q ? PICK : I_SET;
        end else if (fifo_ne && init_q) begin
          state_d = PICK;
        end
      end
      I_SET: begin
        if (!pause) begin
          state_d = I_SEND;
          tx_d    = 1'b1;
        end
      end
      I_SEND: begin
        if (tx_done) begin
          state_d = cmd_finished ? CLR : I_SET;
          init_d  = init_q | cmd_finished;
        end
      end
      PICK: begin
        if (!pick_q) begin
          pick_d    = 1'b1;
          cell_sw_d = sweep_q;
          x_d       = sweep_q ? sx_q : fifo_q[rd_q][7:4];
          y_d       = sweep_q ? sy_q : fifo_q[rd_q][3:0];
        end else begin
          pick_d  = 1'b0;
          obj_d   = obj_in;
          state_d = C_SET;
        end
      end
      C_SET: begin
        state_d = C_SEND;
        tx_d    = 1'b1;
      end
      C_SEND: begin
        if (tx_done) state_d = cmd_finished ? CLR : C_SET;
      end
      CLR: begin
        cell_sw_d = 1'b0;
        if (cell_sw_q) begin
          sx_d = (sx_q == 4'd11) ? 4'd0 : sx_q + 4'd1;
          sy_d = (sx_q == 4'd11) ? sy_q + 4'd1 : sy_q;
          if (sx_q == 4'd11 && sy_q == 4'd15) sweep_d = 1'b0;
        end
        state_d = (sweep_d || fifo_ne) ? PICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sweep_q   <= 1'b0;
      init_q    <= 1'b0;
      oob_q     <= 1'b0;
      pick_q    <= 1'b0;
      cell_sw_q <= 1'b0;
      tx_q      <= 1'b0;
      sx_q      <= 4'd0;
      sy_q      <= 4'd0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      obj_q     <= 3'd0;
      wr_q      <= 2'd0;
      rd_q      <= 2'd0;
      cnt_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      init_q    <= init_d;
      oob_q     <= oob_d;
      pick_q    <= pick_d;
      cell_sw_q <= cell_sw_d;
      tx_q      <= tx_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      obj_q     <= obj_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (store) fifo_q[wr_q] <= {upd_x, upd_y};
  end
  always_comb begin
    mode      = (state_q == I_SET)  ? 3'd1 :
                (state_q == I_SEND) ? 3'd2 :
                (state_q == C_SET)  ? 3'd3 :
                (state_q == C_SEND) ? 3'd4 : 3'd0;
    lut_clr   = state_q == CLR;
    busy      = state_q != IDLE;
    X         = x_q;
    Y         = y_q;
    obj_code  = obj_q;
    tx_start  = tx_q;
    init_done = init_q;
    err_oob   = oob_q;
  end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed milestones plus randomized traffic against a cycle-level behavioural model.
module tb_draw_scheduler;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, upd_valid = 1'b0;
  logic       cmd_finished = 1'b0, pause = 1'b0, tx_done = 1'b0;
  logic [3:0] upd_x = 4'd0, upd_y = 4'd0;
  logic [2:0] obj_in, mode, obj_code;
  logic [3:0] X, Y;
  logic       upd_ready, tx_start, lut_clr, busy, init_done, err_oob;
  int         checks = 0, errors = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  draw_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_x(upd_x), .upd_y(upd_y), .obj_in(obj_in), .cmd_finished(cmd_finished),
    .pause(pause), .tx_done(tx_done), .mode(mode), .X(X), .Y(Y), .obj_code(obj_code),
    .tx_start(tx_start), .lut_clr(lut_clr), .busy(busy), .init_done(init_done), .err_oob(err_oob)
  );

  function automatic logic [2:0] board_obj(logic [3:0] cx, logic [3:0] cy);
    int v;
    v = int'(cx) * 5 + int'(cy) * 3 + int'(cx) * int'(cy) + 3;
    return (cx < 4'd12) ? 3'(v % 8) : 3'd0;
  endfunction
  assign obj_in = board_obj(X, Y);

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: job phases, sweep as a linear cell index, FIFO as a queue.
  localparam int P_IDLE = 0, P_ISET = 1, P_ISEND = 2, P_ADDR = 3, P_OBJ = 4, P_CSET = 5, P_CSEND = 6, P_CLR = 7;
  int         ph, sweep_idx, qn;
  bit         sweep_on, cell_sw, m_init, m_oob, m_txs;
  logic [3:0] mx, my;
  logic [2:0] mobj;
  logic [7:0] q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_IDLE; sweep_idx = 0; sweep_on = 0; cell_sw = 0; m_init = 0; m_oob = 0; m_txs = 0;
      mx = 0; my = 0; mobj = 0; q.delete();
    end else begin
      qn = q.size();
      m_txs = 0;
      case (ph)
        P_IDLE: if (start) begin sweep_on = 1; ph = m_init ? P_ADDR : P_ISET; end
                else if (qn > 0 && m_init) ph = P_ADDR;
        P_ISET: if (!pause) begin ph = P_ISEND; m_txs = 1; end
        P_ISEND: if (tx_done) begin
                   if (cmd_finished) begin ph = P_CLR; m_init = 1; end else ph = P_ISET;
                 end
        P_ADDR: begin
          if (sweep_on) begin mx = 4'(sweep_idx % 12); my = 4'(sweep_idx / 12); cell_sw = 1; end
          else begin {mx, my} = q.pop_front(); cell_sw = 0; end
          ph = P_OBJ;
        end
        P_OBJ: begin mobj = board_obj(mx, my); ph = P_CSET; end
        P_CSET: begin ph = P_CSEND; m_txs = 1; end
        P_CSEND: if (tx_done) ph = cmd_finished ? P_CLR : P_CSET;
        default: begin
          if (cell_sw) begin
            sweep_idx++;
            if (sweep_idx == 192) begin sweep_idx = 0; sweep_on = 0; end
          end
          cell_sw = 0;
          ph = (sweep_on || qn > 0) ? P_ADDR : P_IDLE;
        end
      endcase
      if (upd_valid && qn < 4) begin
        if (upd_x > 4'd11) m_oob = 1; else q.push_back({upd_x, upd_y});
      end
    end
  end

  function automatic logic [2:0] m_mode();
    return (ph == P_ISET) ? 3'd1 : (ph == P_ISEND) ? 3'd2 : (ph == P_CSET) ? 3'd3 : (ph == P_CSEND) ? 3'd4 : 3'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("mode", mode, m_mode());
      chk("lut_clr", lut_clr, ph == P_CLR);
      chk("busy", busy, ph != P_IDLE);
      chk("tx_start", tx_start, m_txs);
      chk("X", X, mx);
      chk("Y", Y, my);
      chk("obj_code", obj_code, mobj);
      chk("init_done", init_done, m_init);
      chk("err_oob", err_oob, m_oob);
      chk("upd_ready", upd_ready, q.size() < 4);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_rand();
    pause = ($urandom_range(0, 3) == 0);
    tx_done = 1'($urandom_range(0, 1));
    cmd_finished = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_chk(string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_X"}, X, 0);
    chk({tag, "_Y"}, Y, 0);
    chk({tag, "_obj"}, obj_code, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_lut_clr"}, lut_clr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_err_oob"}, err_oob, 0);
    chk({tag, "_upd_ready"}, upd_ready, 1);
  endtask

  initial begin
    int n, k, n_clr;
    bit rdy, sweep_done, full_seen, reached;
    logic [7:0] e [5];
    e[0] = {4'd2, 4'd5}; e[1] = {4'd7, 4'd1}; e[2] = {4'd0, 4'd9}; e[3] = {4'd10, 4'd14}; e[4] = {4'd4, 4'd4};
    rst = 1'b1;
    repeat (3) cyc();
    reset_chk("rst");
    rst = 1'b0;
    chk_en = 1'b1;
    // Init with a LUT pause of 5 cycles.
    start = 1'b1; pause = 1'b1;
    cyc();
    start = 1'b0;
    n = (mode == 3'd1);
    for (int i = 0; i < 5; i++) begin cyc(); n += (mode == 3'd1); end
    pause = 1'b0;
    cyc();
    chk("seti_cycles", 16'(n), 6);
    chk("sendi_mode", mode, 2);
    n = tx_start;
    cyc(); n += tx_start;
    cyc(); n += tx_start;
    chk("sendi_tx_pulses", 16'(n), 1);
    cmd_finished = 1'b1; tx_done = 1'b1;
    cyc();
    cmd_finished = 1'b0; tx_done = 1'b0;
    chk("init_lut_clr", lut_clr, 1);
    chk("init_done_set", init_done, 1);
    repeat (3) cyc();
    chk("first_mode", mode, 3);
    chk("first_X", X, 0);
    chk("first_Y", Y, 0);
    chk("first_obj", obj_code, 3);
    // Sweep with five queued requests issued early; the fifth must wait for a pop.
    k = 0; n_clr = 0; sweep_done = 0; full_seen = 0;
    for (int c = 0; c < 8000; c++) begin
      lut_rand();
      upd_valid = (c >= 20 && k < 5);
      {upd_x, upd_y} = e[k % 5];
      rdy = upd_ready;
      cyc();
      if (upd_valid && rdy) begin
        k++;
        if (k == 5) chk("fifth_after_sweep", sweep_done, 1);
      end
      if (k == 4 && !full_seen) begin full_seen = 1; chk("fifo_full_ready", upd_ready, 0); end
      if (lut_clr && !sweep_done) begin
        n_clr++;
        if (X == 4'd11 && Y == 4'd15) begin sweep_done = 1; chk("sweep_clr_count", 16'(n_clr), 192); end
      end
      if (sweep_done && k == 5 && !busy) break;
    end
    upd_valid = 1'b0;
    chk("sweep_done", sweep_done, 1);
    chk("sweep_idle", busy, 0);
    // Out-of-range request.
    tx_done = 1'b0;
    upd_valid = 1'b1; upd_x = 4'd12; upd_y = 4'd3;
    cyc();
    upd_valid = 1'b0;
    chk("oob_flag", err_oob, 1);
    n = 0;
    repeat (4) begin cyc(); n += busy; end
    chk("oob_no_draw", 16'(n), 0);
    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      lut_rand();
      start = ($urandom_range(0, 999) == 0);
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_x = 4'($urandom_range(0, 13));
      upd_y = 4'($urandom_range(0, 15));
      cyc();
    end
    start = 1'b0; upd_valid = 1'b0;
    // Reset in the middle of C_SEND.
    tx_done = 1'b0; cmd_finished = 1'b0; pause = 1'b0;
    upd_x = 4'd5; upd_y = 4'd6;
    reached = 0;
    for (int c = 0; c < 3000; c++) begin
      upd_valid = (c == 0) || !upd_ready ? upd_ready : 1'b0;
      cyc();
      upd_valid = 1'b0;
      if (mode == 3'd4) begin reached = 1; break; end
    end
    chk("csend_reached", reached, 1);
    rst = 1'b1;
    #1;
    reset_chk("arst");
    cyc();
    rst = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rerun_init", mode, 1);
    repeat (5) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request for display init (if not yet done) followed by a full-grid redraw.
REQ-004 upd_valid / upd_ready  input / output  1 / 1  single-cell redraw request handshake; a transfer occurs on a cycle where both are 1.
REQ-005 upd_x, upd_y  input  4 / 4  cell coordinates of the request.
REQ-006 obj_in  input  3  object code of the cell at (X, Y), from board memory, combinational in the same cycle.
REQ-007 cmd_finished, pause  input  1 / 1  from the command LUT.
REQ-008 tx_done  input  1  one-cycle pulse from the byte transmitter when the current byte is sent.
REQ-009 mode  output  3  LUT mode: IDLE=0, SET_I=1, SEND_I=2, SET=3, SEND=4.
REQ-010 X, Y, obj_code  output  4 / 4 / 3  registered cell address and object code driven to the LUT.
REQ-011 tx_start  output  1  one-cycle pulse requesting transmission of the LUT byte.
REQ-012 lut_clr  output  1  one-cycle pulse that clears the LUT command counter.
REQ-013 busy, init_done, err_oob  output  1 each  status flags.

Function
REQ-014 The grid SHALL be 12 columns (X 0..11) by 16 rows (Y 0..15).
REQ-015 States SHALL be IDLE, I_SET, I_SEND, PICK, C_SET, C_SEND, and CLR.
REQ-016 IDLE: start=1 with init_done=0 -> I_SET; start=1 with init_done=1 -> PICK with sweep flag set; otherwise, if the FIFO is non-empty and init_done=1 -> PICK.
REQ-017 start=1 with init_done=0 SHALL also set the sweep flag, so the full redraw follows init.
REQ-018 I_SET: mode=SET_I; stay while pause=1; on pause=0 -> I_SEND next cycle.
REQ-019 I_SEND: mode=SEND_I; tx_start pulses on the first cycle; on tx_done: if cmd_finished -> CLR and set init_done, else -> I_SET.
REQ-020 PICK: if the sweep flag is set, load (X, Y) from the sweep counters; else pop the FIFO head into (X, Y).
REQ-021 PICK: obj_code SHALL be registered from obj_in one cycle after the address is loaded; PICK lasts 2 cycles, then -> C_SET.
REQ-022 C_SET: mode=SET for exactly 1 cycle, then -> C_SEND.
REQ-023 C_SEND: mode=SEND; tx_start pulses on the first cycle; on tx_done: if cmd_finished -> CLR, else -> C_SET.
REQ-024 CLR: mode=IDLE and lut_clr=1 for 1 cycle.
REQ-025 CLR, sweep in progress: advance X 0..11, then wrap X to 0 and increment Y; after (11, 15), clear the sweep flag and reset the counters to 0.
REQ-026 CLR exit: -> PICK if the sweep flag is still set or the FIFO is non-empty; else -> IDLE.
REQ-027 Priority SHALL be: the sweep completes entirely before any FIFO entry is served.
REQ-028 FIFO: 4 entries; upd_ready = not full; a push and a pop in the same cycle are both honoured; a push when full is not possible (ready=0).
REQ-029 A request with upd_x>11 SHALL be accepted, discarded (not stored), and set err_oob (sticky until reset).
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 Requests received before init_done SHALL be queued but not served until init completes.
REQ-032 busy = (state != IDLE).
REQ-033 Outputs other than mode and lut_clr SHALL be held stable between state changes.

Reset
REQ-034 On rst=1, asynchronously: state=IDLE, mode=IDLE, X=Y=0, obj_code=0, tx_start=0, lut_clr=0, busy=0, init_done=0, err_oob=0, FIFO empty (upd_ready=1), sweep flag=0, sweep counters=0.
REQ-035 Reset mid-operation SHALL abandon the transfer with no further tx_start; init SHALL be rerun on the next start.

Verification
REQ-036 Reset, start pulse, LUT pause=1 for 5 cycles -> mode=SET_I held for 6 cycles, then SEND_I with one tx_start.
REQ-037 Init completes (cmd_finished with tx_done) -> lut_clr pulse, init_done=1, first cell at X=0, Y=0 with obj_code equal to obj_in.
REQ-038 Full sweep -> exactly 192 lut_clr pulses after init, last cell (11, 15), then busy=0.
REQ-039 Push 5 requests while busy, with no pops -> upd_ready=0 after 4 accepted; the 5th is held until the first pop.
REQ-040 Request upd_x=12, upd_y=3 -> accepted, err_oob=1, no cell drawn.
REQ-041 Assert rst during C_SEND -> all outputs at reset values immediately; the next start reruns SET_I.
